// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states, constants and per-stage control encodings for hazard_ctrl.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         PERF_CNT_W = 32;

    // Control vector: {pc_s, ifid_s, idex_s, exmem_s, memwb_s, ifid_f, idex_f, redirect}
    localparam logic [7:0] CTL_NONE   = 8'b00000_000;
    localparam logic [7:0] CTL_STALL  = 8'b11111_000;
    localparam logic [7:0] CTL_BRANCH = 8'b00000_111;
    localparam logic [7:0] CTL_BUBBLE = 8'b11000_010;
    localparam logic [7:0] CTL_RESET  = 8'b00000_110;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating stall/flush/load-use event counters, cleared by rst.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_inc,
    input  logic                  flush_inc,
    input  logic                  lu_inc,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_cnt,
    output logic [PERF_CNT_W-1:0] loaduse_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cnt    <= '0;
            loaduse_cnt  <= '0;
        end else begin
            if (stall_inc && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
            if (flush_inc && !(&flush_cnt))    flush_cnt    <= flush_cnt + 1'b1;
            if (lu_inc && !(&loaduse_cnt))     loaduse_cnt  <= loaduse_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: per-stage stall/flush control for load-use, taken branch and cache stalls.
// Define HAZARD_PERF_CNT_EN to add saturating performance counter outputs.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            ID_RS1addr_i,
    input  logic [4:0]            ID_RS2addr_i,
    input  logic [4:0]            EX_RDaddr_i,
    input  logic                  EX_MemRead_i,
    input  logic                  EX_branch_taken_i,
    input  logic                  ICache_stall_i,
    input  logic                  DCache_stall_i,
    output logic                  pc_stall_o,
    output logic                  ifid_stall_o,
    output logic                  idex_stall_o,
    output logic                  exmem_stall_o,
    output logic                  memwb_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic                  redirect_o
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [PERF_CNT_W-1:0] stall_cycles_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o,
    output logic [PERF_CNT_W-1:0] loaduse_cnt_o
`endif
);

    state_e     state, state_nxt;
    logic       flush_pend, pend_nxt;
    logic       mem_stall, load_use;
    logic [7:0] ctl;

    assign mem_stall = ICache_stall_i | DCache_stall_i;
    assign load_use  = EX_MemRead_i && EX_RDaddr_i != REG_ZERO &&
                       (EX_RDaddr_i == ID_RS1addr_i || EX_RDaddr_i == ID_RS2addr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= pend_nxt;
        end
    end

    // A branch seen during a stall is remembered and replayed as a FLUSH cycle,
    // since the pipeline registers ignore flush while stalled.
    always_comb begin
        state_nxt = state;
        pend_nxt  = flush_pend;
        ctl       = CTL_NONE;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    ctl       = CTL_STALL;
                    state_nxt = MEM_WAIT;
                    pend_nxt  = EX_branch_taken_i;
                end else begin
                    ctl = EX_branch_taken_i ? CTL_BRANCH : load_use ? CTL_BUBBLE : CTL_NONE;
                end
            end
            MEM_WAIT: begin
                ctl      = CTL_STALL;
                pend_nxt = flush_pend | EX_branch_taken_i;
                if (!mem_stall) state_nxt = pend_nxt ? FLUSH : RUN;
            end
            FLUSH: begin
                ctl       = CTL_BRANCH;
                state_nxt = RUN;
                pend_nxt  = 1'b0;
            end
            default: begin
                state_nxt = RUN;
                pend_nxt  = 1'b0;
            end
        endcase
        if (rst) ctl = CTL_RESET;
    end

    assign {pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o,
            ifid_flush_o, idex_flush_o, redirect_o} = ctl;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (ctl[7]),
        .flush_inc    (ctl[0]),
        .lu_inc       (ctl == CTL_BUBBLE),
        .stall_cycles (stall_cycles_o),
        .flush_cnt    (flush_cnt_o),
        .loaduse_cnt  (loaduse_cnt_o)
    );
`endif

endmodule
